// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response channel,
// the redirect input, and the decode-side handshake.
interface fetch_if;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;

  modport master (
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_req_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output valid_o,
    input  ready_i,
    output pc_o,
    output instr_o
  );

  modport slave (
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_req_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  valid_o,
    output ready_i,
    input  pc_o,
    input  instr_o
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited pipelined memory requests feeding a
// 2-entry {pc, instr} FIFO, with redirect flush and stale-response discard.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk_i,
  input logic    rst_n_i,
  fetch_if.master bus
);

  logic [31:0] r_reqPc;
  logic [31:0] r_rspPc;
  logic [1:0]  r_inflight;
  logic [1:0]  r_discard;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_fifoPc    [2];
  logic [31:0] r_fifoInstr [2];

  logic        w_redirect;
  logic        w_valid;
  logic        w_pop;
  logic        w_reqValid;
  logic        w_fire;
  logic        w_rspValid;
  logic        w_push;
  logic        w_tail;
  logic [1:0]  w_live;
  logic [2:0]  w_credit;
  logic [31:0] w_redirPc;

  assign w_redirect = bus.redirect_valid_i;
  assign w_rspValid = bus.imem_rsp_valid_i;
  assign w_redirPc  = bus.redirect_pc_i & ~32'h0000_0003;

  assign w_valid = (r_count != 2'd0) && !w_redirect;
  assign w_pop   = w_valid && bus.ready_i;

  // Credit counts live requests plus buffered entries, so every live response has a slot.
  assign w_live     = r_inflight - r_discard;
  assign w_credit   = {1'b0, w_live} + {1'b0, r_count} - {2'b00, w_pop};
  assign w_reqValid = rst_n_i && !w_redirect && (r_inflight < 2'd2) && (w_credit < 3'd2);
  assign w_fire     = w_reqValid && bus.imem_req_ready_i;

  assign w_push = w_rspValid && (r_discard == 2'd0) && !w_redirect;
  assign w_tail = r_head ^ r_count[0];

  assign bus.imem_req_valid_o = w_reqValid;
  assign bus.imem_req_addr_o  = r_reqPc;
  assign bus.valid_o          = w_valid;
  assign bus.pc_o             = r_fifoPc[r_head];
  assign bus.instr_o          = r_fifoInstr[r_head];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_reqPc        <= RESET_PC;
      r_rspPc        <= RESET_PC;
      r_inflight     <= 2'd0;
      r_discard      <= 2'd0;
      r_count        <= 2'd0;
      r_head         <= 1'b0;
      r_fifoPc[0]    <= 32'd0;
      r_fifoPc[1]    <= 32'd0;
      r_fifoInstr[0] <= 32'd0;
      r_fifoInstr[1] <= 32'd0;
    end else if (w_redirect) begin
      // Everything still outstanding becomes stale; a response landing now is dropped too.
      r_reqPc    <= w_redirPc;
      r_rspPc    <= w_redirPc;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_inflight <= r_inflight - {1'b0, w_rspValid};
      r_discard  <= r_inflight - {1'b0, w_rspValid};
    end else begin
      if (w_fire) begin
        r_reqPc <= r_reqPc + 32'd4;
      end
      r_inflight <= r_inflight + {1'b0, w_fire} - {1'b0, w_rspValid};
      if (w_rspValid && (r_discard != 2'd0)) begin
        r_discard <= r_discard - 2'd1;
      end
      if (w_push) begin
        r_fifoPc[w_tail]    <= r_rspPc;
        r_fifoInstr[w_tail] <= bus.imem_rsp_data_i;
        r_rspPc             <= r_rspPc + 32'd4;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: an in-order memory model with per-request epochs
// decides which responses must reach decode; pops are checked against the queue.
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rstN;
  fetch_if bus();

  fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i  (clk),
    .rst_n_i(rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compCount;
  int errCount;
  int cycle;
  int epoch;
  int memLat;
  int decMode;
  int popCount;
  logic memRdyRand;
  logic [31:0] expReqAddr;
  memReq_t pending[$];
  exp_t    sbQ[$];
  logic [31:0] reqLog[$];

  logic        redirNext;
  logic [31:0] redirPcNext;

  logic        sReqValid, sMemReady, sValid, sReady, sRspNow, sRedir;
  logic [31:0] sReqAddr, sPc, sInstr;
  int          sPending;
  logic        prevHold, prevReqWait;
  logic [31:0] prevPc, prevInstr, prevReqAddr;
  logic        firstPopSeen;
  logic [31:0] firstPopPc;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rstN = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'd0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 32'd0;
    bus.ready_i          = 1'b0;
    #1;
    checkOutput("rstReqValid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    checkOutput("rstValid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("rstPc", bus.pc_o, 32'd0);
    checkOutput("rstInstr", bus.instr_o, 32'd0);
    pending.delete();
    sbQ.delete();
    reqLog.delete();
    epoch++;
    expReqAddr   = RESET_PC;
    cycle        = 0;
    prevHold     = 1'b0;
    prevReqWait  = 1'b0;
    firstPopSeen = 1'b0;
    redirNext    = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, update the models.
  task automatic applyStimulus();
    memReq_t m;
    int liveCnt;
    int lat;
    @(negedge clk);
    rstN = 1'b1;
    bus.redirect_valid_i = redirNext;
    bus.redirect_pc_i    = redirNext ? redirPcNext : $urandom();
    redirNext = 1'b0;
    bus.ready_i = (decMode == 1) ? 1'b1 : (decMode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.imem_req_ready_i = memRdyRand ? ($urandom_range(0, 3) != 0) : 1'b1;
    sRspNow = (pending.size() > 0) && (pending[0].due <= cycle);
    bus.imem_rsp_valid_i = sRspNow;
    bus.imem_rsp_data_i  = sRspNow ? memWord(pending[0].addr) : $urandom();
    #1;
    sReqValid = bus.imem_req_valid_o;
    sReqAddr  = bus.imem_req_addr_o;
    sMemReady = bus.imem_req_ready_i;
    sValid    = bus.valid_o;
    sReady    = bus.ready_i;
    sPc       = bus.pc_o;
    sInstr    = bus.instr_o;
    sRedir    = bus.redirect_valid_i;
    sPending  = pending.size();

    liveCnt = 0;
    foreach (pending[i]) if (pending[i].epoch == epoch) liveCnt++;
    checkOutput("inflightMax", {31'd0, pending.size() <= 2}, 32'd1);
    checkOutput("credit", {31'd0, (liveCnt + sbQ.size()) <= 2}, 32'd1);
    checkOutput("validO", {31'd0, sValid}, {31'd0, (sbQ.size() != 0) && !sRedir});
    if (sRedir) checkOutput("reqInRedirect", {31'd0, sReqValid}, 32'd0);
    if (prevHold && !sRedir) begin
      checkOutput("stallPc", sPc, prevPc);
      checkOutput("stallInstr", sInstr, prevInstr);
    end
    if (prevReqWait && !sRedir) begin
      checkOutput("reqHoldValid", {31'd0, sReqValid}, 32'd1);
      checkOutput("reqHoldAddr", sReqAddr, prevReqAddr);
    end

    if (sValid && sReady && (sbQ.size() > 0)) begin
      checkOutput("popPc", sPc, sbQ[0].pc);
      checkOutput("popInstr", sInstr, sbQ[0].instr);
      void'(sbQ.pop_front());
      popCount++;
      if (!firstPopSeen) begin
        firstPopSeen = 1'b1;
        firstPopPc   = sPc;
      end
    end

    if (sRspNow) begin
      m = pending.pop_front();
      if ((m.epoch == epoch) && !sRedir) sbQ.push_back('{pc: m.addr, instr: memWord(m.addr)});
    end

    if (sReqValid && sMemReady) begin
      checkOutput("reqAddr", sReqAddr, expReqAddr);
      expReqAddr = expReqAddr + 32'd4;
      lat = (memLat == 0) ? $urandom_range(1, 7) : memLat;
      pending.push_back('{addr: sReqAddr, epoch: epoch, due: cycle + lat});
      reqLog.push_back(sReqAddr);
    end

    if (sRedir) begin
      epoch++;
      expReqAddr   = {bus.redirect_pc_i[31:2], 2'b00};
      sbQ.delete();
      reqLog.delete();
      firstPopSeen = 1'b0;
    end

    prevHold    = sValid && !sReady && !sRedir;
    prevPc      = sPc;
    prevInstr   = sInstr;
    prevReqWait = sReqValid && !sMemReady && !sRedir;
    prevReqAddr = sReqAddr;
    @(posedge clk);
    cycle++;
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    redirNext   = 1'b1;
    redirPcNext = pc;
    applyStimulus();
  endtask

  task automatic checkFirstReqs(input string tag, input logic [31:0] a0, input logic [31:0] a1);
    checkOutput({tag, "Count"}, {31'd0, reqLog.size() >= 2}, 32'd1);
    if (reqLog.size() >= 2) begin
      checkOutput({tag, "Req0"}, reqLog[0], a0);
      checkOutput({tag, "Req1"}, reqLog[1], a1);
    end
  endtask

  initial begin
    compCount = 0;
    errCount  = 0;
    epoch     = 0;
    popCount  = 0;
    rstN      = 1'b0;
    memLat    = 1;
    decMode   = 1;
    memRdyRand = 1'b0;
    redirNext  = 1'b0;
    redirPcNext = 32'd0;
    firstPopPc  = 32'd0;
    resetDut();

    for (int c = 0; c < 12; c++) begin
      applyStimulus();
      if (c == 0) begin
        checkOutput("firstReqValid", {31'd0, sReqValid}, 32'd1);
        checkOutput("firstReqAddr", sReqAddr, RESET_PC);
      end
      if (c >= 2) checkOutput("streamValid", {31'd0, sValid}, 32'd1);
    end
    checkOutput("streamFirstPc", firstPopPc, RESET_PC);
    checkFirstReqs("stream", RESET_PC, RESET_PC + 32'd4);

    decMode = 0;
    repeat (5) applyStimulus();
    checkOutput("stallNoReq", {31'd0, sReqValid}, 32'd0);
    checkOutput("stallValid", {31'd0, sValid}, 32'd1);
    decMode = 1;
    repeat (6) applyStimulus();

    memLat = 6;
    repeat (3) applyStimulus();
    redirectTo(32'h0000_2002);
    checkOutput("redirInflight", sPending, 32'd2);
    memLat = 1;
    repeat (14) applyStimulus();
    checkOutput("redirFirstPc", firstPopPc, 32'h0000_2000);
    checkFirstReqs("redir", 32'h0000_2000, 32'h0000_2004);

    repeat (4) applyStimulus();
    redirectTo(32'h0000_3000);
    checkOutput("coincRsp", {31'd0, sRspNow}, 32'd1);
    checkOutput("coincReady", {31'd0, sReady}, 32'd1);
    checkOutput("coincValid", {31'd0, sValid}, 32'd0);
    repeat (8) applyStimulus();
    checkOutput("coincFirstPc", firstPopPc, 32'h0000_3000);

    redirectTo(32'hFFFF_FFFC);
    repeat (8) applyStimulus();
    checkFirstReqs("wrap", 32'hFFFF_FFFC, 32'h0000_0000);
    checkOutput("wrapFirstPc", firstPopPc, 32'hFFFF_FFFC);

    memLat = 3;
    repeat (5) applyStimulus();
    redirectTo(32'h0000_4000);
    redirectTo(32'h0000_5008);
    memLat = 1;
    repeat (15) applyStimulus();
    checkOutput("b2bFirstPc", firstPopPc, 32'h0000_5008);
    checkFirstReqs("b2b", 32'h0000_5008, 32'h0000_500C);

    memLat = 4;
    repeat (3) applyStimulus();
    resetDut();
    memLat = 1;
    repeat (8) applyStimulus();
    checkOutput("rerstFirstPc", firstPopPc, RESET_PC);

    memLat     = 0;
    memRdyRand = 1'b1;
    decMode    = 2;
    popCount   = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 29) == 0) redirectTo($urandom());
      else applyStimulus();
    end
    checkOutput("randomProgress", {31'd0, popCount > 50}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1 bit, meaning the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit, meaning the reset; it is asynchronous and active-low.
REQ-004 SHALL have port imem_req_valid_o, output, 1 bit, meaning an instruction-memory request is offered.
REQ-005 SHALL have port imem_req_ready_i, input, 1 bit, meaning memory accepts the request this cycle.
REQ-006 SHALL have port imem_req_addr_o, output, 32 bits (types::word_t), meaning the word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid_i, input, 1 bit, meaning a response is present; it is always accepted with no backpressure.
REQ-008 SHALL have port imem_rsp_data_i, input, 32 bits, meaning the instruction word, returned in request order.
REQ-009 SHALL have port redirect_valid_i, input, 1 bit, meaning flush and restart fetch.
REQ-010 SHALL have port redirect_pc_i, input, 32 bits, meaning the restart address.
REQ-011 SHALL have port valid_o, output, 1 bit, meaning pc_o and instr_o hold a valid instruction for decode.
REQ-012 SHALL have port ready_i, input, 1 bit, meaning decode consumes the head entry.
REQ-013 SHALL have port pc_o, output, 32 bits, meaning the address of instr_o; it drives decode pc_i.
REQ-014 SHALL have port instr_o, output, 32 bits, meaning the instruction word; it drives decode instr_i.

Function
REQ-015 SHALL hold req_pc (next request address), rsp_pc (address of next live response), inflight count (0..2), discard count (0..inflight), and a 2-entry FIFO of {pc, instr}.
REQ-016 SHALL issue a request handshake on imem_req_valid_o && imem_req_ready_i; req_pc += 4 (mod 2^32 wrap) and inflight += 1.
REQ-017 SHALL assert imem_req_valid_o iff !redirect_valid_i && inflight < 2 && (inflight - discard) + fifo_count - pop < 2, where pop = valid_o && ready_i; this gives full throughput with 1-cycle memory latency.
REQ-018 SHALL keep imem_req_addr_o = req_pc stable while imem_req_valid_o is high and unaccepted; withdrawal is permitted only in a redirect cycle.
REQ-019 SHALL decrement inflight on each response; a response arriving while discard > 0 is dropped and discard -= 1; otherwise {rsp_pc, imem_rsp_data_i} is pushed to the FIFO and rsp_pc += 4.
REQ-020 SHALL never overflow the FIFO, because credit (REQ-017) guarantees a slot per live response; a push and a pop in the same cycle are both honoured.
REQ-021 SHALL drive valid_o = (fifo_count != 0) && !redirect_valid_i, with pc_o and instr_o taken from the FIFO head; pop on valid_o && ready_i.
REQ-022 SHALL, on redirect_valid_i, perform all of the following in that cycle:
  - empty the FIFO and ignore any pop;
  - set req_pc and rsp_pc to {redirect_pc_i[31:2], 2'b00};
  - set discard to inflight minus any response arriving that cycle, with the arriving response dropped.
REQ-023 SHALL treat back-to-back redirects identically; the last one wins and discards accumulate correctly.
REQ-024 SHALL keep pc_o and instr_o stable while valid_o && !ready_i, except on a redirect.

Reset
REQ-025 SHALL, while rst_n_i is low, force imem_req_valid_o = 0, valid_o = 0, inflight = 0, discard = 0, FIFO empty, req_pc = rsp_pc = RESET_PC, and pc_o = instr_o = 0.
REQ-026 SHALL allow its first request in the first rising edge after rst_n_i deasserts, with imem_req_addr_o = RESET_PC.
REQ-027 SHALL, on reset asserted mid-operation, abandon all in-flight requests; the bench must not return responses to pre-reset requests.

Verification
REQ-028 SHALL pass streaming: 1-cycle memory, ready_i = 1, RESET_PC = 0x100 -> valid_o every cycle from cycle 2, pc_o = 0x100, 0x104, 0x108 ..., and instr_o matches memory.
REQ-029 SHALL pass decode stall: ready_i = 0 for 5 cycles -> at most 2 live entries; imem_req_valid_o low once credit is exhausted; pc_o/instr_o stable; no loss or reorder after release.
REQ-030 SHALL pass redirect with 2 in flight: redirect to 0x2002 -> both stale responses dropped, next request address 0x2000, first valid pc_o = 0x2000.
REQ-031 SHALL pass redirect coinciding with a response and a pop -> the response is dropped, the pop is ignored, and valid_o is low that cycle.
REQ-032 SHALL pass wrap: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-033 SHALL pass variable latency 1-7 cycles and random imem_req_ready_i -> pc_o is strictly sequential between redirects and inflight never exceeds 2.
